truth_table_sequencer: RTL and testbench
========================================

Name: truth_table_sequencer

Overview:
Controller that drives the decoder-based function datapath through every input combination and checks each result. It applies vector x = 0..2^N_IN-1, waits for the combinational path to settle, samples the function outputs and compares them to a parameterised expected truth table. The vectors advance either on an internal clock-divider tick (auto mode) or on a single-step pulse. Pass/fail status, the failing-vector map and an error count are held until the next start.

Parameters:
DIV_WIDTH, 25, divider width; auto mode paces one vector per 2^DIV_WIDTH clocks.
N_IN, 3, datapath input width; the sweep covers 2^N_IN vectors.
N_OUT, 3, number of function outputs sampled.
SETTLE, 2, clocks between driving x_out and sampling f_in (minimum 1).
EXPECTED, 24'h18B685, expected outputs. Bits [v*N_OUT +: N_OUT] = {z2,z1,z0} for vector v. Width is N_OUT*2^N_IN.

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-clock pulse; begins a sweep from vector 0
mode_auto  in  1  1 = divider pacing; 0 = advance on step
step  in  1  one-clock pulse; advances one vector when mode_auto=0
f_in  in  N_OUT  function outputs from the datapath
x_out  out  N_IN  vector driven into the decoder
busy  out  1  high from start until DONE
done  out  1  high in DONE; cleared by start
pass  out  1  valid when done=1; high if err_count=0
fail_map  out  2^N_IN  bit v set if vector v mismatched
err_count  out  N_IN+1  number of mismatching vectors

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, x_out=0, busy=0, done=0, pass=0, fail_map=0, err_count=0, divider=0, settle counter=0.
- States: IDLE, APPLY, SETTLE, SAMPLE, WAIT, DONE.
- IDLE: on start, go to APPLY. x_out=0, fail_map=0, err_count=0, divider cleared, busy=1.
- APPLY: one clock; x_out holds the current vector. Go to SETTLE and load the settle counter with SETTLE-1.
- SETTLE: count down to 0, then go to SAMPLE. f_in is therefore sampled SETTLE+1 clocks after x_out changes.
- SAMPLE: one clock. Compare f_in with EXPECTED[x_out*N_OUT +: N_OUT]. On mismatch, set fail_map[x_out] and increment err_count.
  - If x_out = 2^N_IN-1: go to DONE.
  - Otherwise: go to WAIT.
- WAIT, leaving conditions:
  - mode_auto=1: when the divider reaches all-ones, increment x_out and go to APPLY.
  - mode_auto=0: on step=1, increment x_out and go to APPLY.
- WAIT, divider and mode rules:
  - The divider runs freely only in WAIT and is cleared on leaving WAIT.
  - mode_auto is sampled every clock in WAIT, so the mode can change mid-sweep.
- DONE: busy=0, done=1, pass=(err_count==0). x_out holds the last vector. On start, clear the results and go to APPLY with x_out=0.
- start while busy (APPLY through WAIT): restarts the sweep from vector 0 and clears the results. A restart always takes priority over a step or tick in the same clock.
- step outside WAIT, or while mode_auto=1: ignored, not queued.
- x_out does not wrap. The sweep ends at 2^N_IN-1 and never increments past it.
- err_count saturates by construction; its maximum is 2^N_IN.
- All outputs are registered. fail_map and err_count update on the clock after SAMPLE.
- Asynchronous reset mid-sweep aborts immediately to the reset values.

Test Plan:
- Correct datapath, EXPECTED default, DIV_WIDTH=3, mode_auto=1, start pulse → x_out steps 0..7; done=1, pass=1, fail_map=8'h00, err_count=0. Each vector spacing is 1+SETTLE+1+8 = 12 clocks, except after the last vector.
- f_in forced to 3'b000 throughout, same setup → done=1, pass=0, err_count=6, fail_map=8'h7D (vectors 0, 2, 3, 4, 5, 6).
- mode_auto=0, start, then 3 step pulses spaced 20 clocks → x_out=3, busy=1, done=0. Extra step pulses during SETTLE produce no advance.
- start pulse while x_out=5 in WAIT → x_out=0 on the next APPLY, fail_map and err_count cleared. A step pulse in the same clock is ignored.
- reset_n driven low for 1 clock mid-SETTLE → all outputs return to their reset values immediately. After release the block stays in IDLE until start.
- Sweep with mode_auto toggled 1→0 in WAIT at x_out=4 → the sweep halts until a step pulse, then completes normally with pass=1.

Source files
------------

// File: rtl/truth_table_sequencer.sv
// Sweeps every input vector through the decoder datapath, samples the function
// outputs after a settle delay and records mismatches against a truth table.
module truth_table_sequencer #(
    parameter int DIV_WIDTH = 25,
    parameter int N_IN      = 3,
    parameter int N_OUT     = 3,
    parameter int SETTLE    = 2,
    parameter logic [N_OUT*(2**N_IN)-1:0] EXPECTED = 24'h18B685
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 mode_auto,
    input  logic                 step,
    input  logic [N_OUT-1:0]     f_in,
    output logic [N_IN-1:0]      x_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   fail_map,
    output logic [N_IN:0]        err_count
);

    // state    | meaning
    // S_IDLE   | waiting for start, results cleared or held from reset
    // S_APPLY  | x_out driven, settle counter loaded
    // S_SETTLE | counting down while the datapath settles
    // S_SAMPLE | f_in compared against the expected row
    // S_WAIT   | paced by divider tick (auto) or step pulse (manual)
    // S_DONE   | sweep finished, results held until next start

    localparam int NVEC = 2**N_IN;
    localparam int SW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NVEC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_APPLY, S_SETTLE, S_SAMPLE, S_WAIT, S_DONE
    } state_t;

    state_t state, state_d;

    logic [DIV_WIDTH-1:0] div_cnt, div_d;
    logic [SW-1:0]        settle_cnt, settle_d;
    logic [N_IN-1:0]      x_d;
    logic [NVEC-1:0]      fail_d;
    logic [N_IN:0]        err_d;
    logic                 busy_d, done_d, pass_d;
    logic [N_OUT-1:0]     exp_f;
    logic                 mismatch;
    logic                 advance;

    assign exp_f    = EXPECTED[x_out*N_OUT +: N_OUT];
    assign mismatch = (f_in != exp_f);
    assign advance  = mode_auto ? (&div_cnt) : step;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_d;
    end

    // start wins over any step or tick in the same clock
    always_comb begin
        state_d = state;
        if (start) begin
            state_d = S_APPLY;
        end else begin
            case (state)
                S_IDLE:   state_d = S_IDLE;
                S_APPLY:  state_d = S_SETTLE;
                S_SETTLE: if (settle_cnt == '0) state_d = S_SAMPLE;
                S_SAMPLE: state_d = (x_out == LAST_VEC) ? S_DONE : S_WAIT;
                S_WAIT:   if (advance) state_d = S_APPLY;
                S_DONE:   state_d = S_DONE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        x_d      = x_out;
        fail_d   = fail_map;
        err_d    = err_count;
        div_d    = div_cnt;
        settle_d = settle_cnt;
        if (start) begin
            x_d    = '0;
            fail_d = '0;
            err_d  = '0;
            div_d  = '0;
        end else begin
            case (state)
                S_APPLY:  settle_d = SW'(SETTLE - 1);
                S_SETTLE: if (settle_cnt != '0) settle_d = settle_cnt - SW'(1);
                S_SAMPLE: begin
                    if (mismatch) begin
                        fail_d[x_out] = 1'b1;
                        err_d         = err_count + (N_IN+1)'(1);
                    end
                end
                S_WAIT: begin
                    if (advance) begin
                        x_d   = x_out + N_IN'(1);
                        div_d = '0;
                    end else begin
                        div_d = div_cnt + DIV_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d == S_APPLY) || (state_d == S_SETTLE) ||
                 (state_d == S_SAMPLE) || (state_d == S_WAIT);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_out      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_map   <= '0;
            err_count  <= '0;
            div_cnt    <= '0;
            settle_cnt <= '0;
        end else begin
            x_out      <= x_d;
            busy       <= busy_d;
            done       <= done_d;
            pass       <= pass_d;
            fail_map   <= fail_d;
            err_count  <= err_d;
            div_cnt    <= div_d;
            settle_cnt <= settle_d;
        end
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench for truth_table_sequencer: directed sweeps with a behavioural
// datapath; a monitor checks x_out transitions and end-of-sweep results.
module tb_truth_table_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       mode_auto = 1'b0;
    logic       step = 1'b0;
    logic       force_zero = 1'b0;
    logic [2:0] f_in;
    logic [2:0] x_out;
    logic       busy, done, pass;
    logic [7:0] fail_map;
    logic [3:0] err_count;

    int n_pass = 0;
    int n_total = 0;

    typedef struct { int x; int gap; } xexp_t;
    typedef struct { logic p; logic [7:0] map; logic [3:0] err; } rexp_t;
    xexp_t x_q[$];
    rexp_t r_q[$];

    truth_table_sequencer #(.DIV_WIDTH(3)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .mode_auto(mode_auto),
        .step(step), .f_in(f_in), .x_out(x_out), .busy(busy), .done(done),
        .pass(pass), .fail_map(fail_map), .err_count(err_count)
    );

    always #5 clock = ~clock;

    // Correct datapath, hand-tabulated {z2,z1,z0} per vector
    function automatic logic [2:0] model(input logic [2:0] v);
        case (v)
            3'd0: model = 3'd5;
            3'd1: model = 3'd0;
            3'd2: model = 3'd2;
            3'd3: model = 3'd3;
            3'd4: model = 3'd3;
            3'd5: model = 3'd1;
            3'd6: model = 3'd6;
            default: model = 3'd0;
        endcase
    endfunction

    assign f_in = force_zero ? 3'b000 : model(x_out);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1; cyc(1); step = 1'b0;
    endtask

    task automatic push_x(input int x, input int gap);
        xexp_t e;
        e.x = x; e.gap = gap;
        x_q.push_back(e);
    endtask

    task automatic push_r(input logic p, input logic [7:0] map, input logic [3:0] err);
        rexp_t e;
        e.p = p; e.map = map; e.err = err;
        r_q.push_back(e);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin cyc(1); n++; end
        chk("done_reached", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_x(input logic [2:0] v, input int budget);
        int n = 0;
        while (x_out !== v && n < budget) begin cyc(1); n++; end
        chk("x_reached", {29'd0, x_out}, {29'd0, v});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"},    {29'd0, x_out}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
        chk({tag, "_map"},  {24'd0, fail_map}, 32'd0);
        chk({tag, "_err"},  {28'd0, err_count}, 32'd0);
    endtask

    // Monitor: pops expectations whenever x_out changes or done rises
    logic       mon_en = 1'b0;
    logic [2:0] x_prev = 3'd0;
    logic       done_prev = 1'b0;
    int         cyc_n = 0;
    int         last_chg = 0;

    always @(negedge clock) begin
        xexp_t xe;
        rexp_t re;
        cyc_n++;
        if (mon_en) begin
            if (x_out !== x_prev) begin
                if (x_q.size() == 0) begin
                    chk("x_unexpected_change", {29'd0, x_out}, {29'd0, x_prev});
                end else begin
                    xe = x_q.pop_front();
                    chk("x_seq", {29'd0, x_out}, xe.x);
                    if (xe.gap >= 0) chk("x_spacing", cyc_n - last_chg, xe.gap);
                end
                last_chg = cyc_n;
            end
            if (done === 1'b1 && done_prev !== 1'b1) begin
                if (r_q.size() == 0) begin
                    chk("done_unexpected", {31'd0, done}, 32'd0);
                end else begin
                    re = r_q.pop_front();
                    chk("res_pass", {31'd0, pass}, {31'd0, re.p});
                    chk("res_map",  {24'd0, fail_map}, {24'd0, re.map});
                    chk("res_err",  {28'd0, err_count}, {28'd0, re.err});
                end
            end
        end
        x_prev    = x_out;
        done_prev = done;
    end

    initial begin
        // reset state
        cyc(2);
        chk_reset_vals("rst");
        reset_n = 1'b1;
        cyc(2);
        mon_en = 1'b1;

        // auto sweep, correct datapath
        mode_auto = 1'b1;
        push_x(1, -1);
        for (int v = 2; v < 8; v++) push_x(v, 12);
        push_r(1'b1, 8'h00, 4'd0);
        pulse_start();
        wait_done(300);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        cyc(20);
        chk("t1_x_hold", {29'd0, x_out}, 32'd7);
        chk("t1_done_hold", {31'd0, done}, 32'd1);

        // auto sweep, outputs stuck at zero; restart from DONE
        force_zero = 1'b1;
        push_x(0, -1);
        for (int v = 1; v < 8; v++) push_x(v, 12);
        push_r(1'b0, 8'h7D, 4'd6);
        pulse_start();
        wait_done(300);

        // manual stepping with extra steps outside WAIT
        mode_auto = 1'b0;
        push_x(0, -1);
        pulse_start();
        cyc(10);
        for (int v = 1; v <= 5; v++) begin
            push_x(v, -1);
            pulse_step();      // seen in WAIT
            pulse_step();      // seen in APPLY, ignored
            pulse_step();      // seen in SETTLE, ignored
            cyc(17);
            if (v == 3) begin
                chk("t3_x", {29'd0, x_out}, 32'd3);
                chk("t3_busy", {31'd0, busy}, 32'd1);
                chk("t3_done", {31'd0, done}, 32'd0);
            end
        end
        chk("t4_err_pre", {28'd0, err_count}, 32'd5);
        chk("t4_map_pre", {24'd0, fail_map}, 32'h3D);

        // restart at x=5 with a simultaneous step
        push_x(0, -1);
        start = 1'b1; step = 1'b1;
        cyc(1);
        start = 1'b0; step = 1'b0;
        chk("t4_x", {29'd0, x_out}, 32'd0);
        chk("t4_map", {24'd0, fail_map}, 32'd0);
        chk("t4_err", {28'd0, err_count}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd1);
        cyc(20);
        chk("t4_x_stay", {29'd0, x_out}, 32'd0);
        chk("t4_err_fresh", {28'd0, err_count}, 32'd1);
        chk("t4_map_fresh", {24'd0, fail_map}, 32'h01);

        // async reset mid-SETTLE
        push_x(1, -1);
        pulse_step();
        cyc(1);
        push_x(0, -1);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        cyc(1);
        reset_n = 1'b1;
        cyc(5);
        pulse_step();
        cyc(15);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_x", {29'd0, x_out}, 32'd0);

        // auto sweep, switch to manual at x=4, one step, then auto again
        force_zero = 1'b0;
        mode_auto  = 1'b1;
        push_x(1, -1);
        for (int v = 2; v <= 4; v++) push_x(v, 12);
        pulse_start();
        wait_x(3'd4, 100);
        cyc(5);
        mode_auto = 1'b0;
        cyc(30);
        chk("t6_x_halt", {29'd0, x_out}, 32'd4);
        chk("t6_busy", {31'd0, busy}, 32'd1);
        push_x(5, -1);
        push_x(6, 12);
        push_x(7, 12);
        push_r(1'b1, 8'h00, 4'd0);
        pulse_step();
        mode_auto = 1'b1;
        wait_done(200);
        cyc(3);

        chk("x_queue_empty", x_q.size(), 32'd0);
        chk("r_queue_empty", r_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
